// File: rtl/commit_stream_checker_pkg.sv
// Shared types and constants for commit_stream_checker.
// Memory-compare entry fields exist only when CHK_MEM_EN is defined.
package commit_chk_pkg;

  localparam int CHK_DATA_W = 32;
  localparam int CHK_REG_W  = 5;

  localparam int ERR_PC   = 0;
  localparam int ERR_REG  = 1;
  localparam int ERR_UNDF = 2;
  localparam int ERR_MEM  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PASS = 2'd2,
    FAIL = 2'd3
  } chk_state_e;

  typedef struct packed {
`ifdef CHK_MEM_EN
    logic                  mwe;
    logic [CHK_DATA_W-1:0] maddr;
    logic [CHK_DATA_W-1:0] mdata;
`endif
    logic [CHK_DATA_W-1:0] pc;
    logic                  we;
    logic [CHK_REG_W-1:0]  rd;
    logic [CHK_DATA_W-1:0] wdata;
  } exp_entry_t;

  localparam int ENTRY_W = $bits(exp_entry_t);

  // A write to r0 has no architectural effect, so it is treated as no write.
  function automatic logic reg_wr_eff(input logic we, input logic [CHK_REG_W-1:0] rd);
    return we && (rd != {CHK_REG_W{1'b0}});
  endfunction

endpackage

// File: rtl/commit_stream_checker_fifo.sv
// Synchronous FIFO holding expected-commit entries; full/empty/level are registered.
module commit_fifo #(
  parameter  int DEPTH = 8,
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LW-1:0]    level_o
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [LW-1:0]    level_r;
  logic [LW-1:0]    level_nxt_s;
  logic             full_r;
  logic             empty_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign push_ok_s = push_i && !full_r;
  assign pop_ok_s  = pop_i && !empty_r;

  // next occupancy from accepted push/pop
  always_comb begin
    level_nxt_s = level_r;
    case ({push_ok_s, pop_ok_s})
      2'b10:   level_nxt_s = level_r + LW'(1);
      2'b01:   level_nxt_s = level_r - LW'(1);
      default: level_nxt_s = level_r;
    endcase
  end

  // pointers and flags; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {LW{1'b0}};
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      level_r <= level_nxt_s;
      full_r  <= (level_nxt_s == LW'(DEPTH));
      empty_r <= (level_nxt_s == {LW{1'b0}});
    end
  end

  // entry storage
  always_ff @(posedge clk_i) begin
    if (push_ok_s) mem_r[wr_ptr_r] <= din_i;
  end

  assign dout_o  = mem_r[rd_ptr_r];
  assign full_o  = full_r;
  assign empty_o = empty_r;
  assign level_o = level_r;

endmodule

// File: rtl/commit_stream_checker.sv
// Compares retired instructions against a buffered expected-commit stream and latches a verdict.
// Optional memory-store comparison is enabled by defining CHK_MEM_EN.
module commit_stream_checker
  import commit_chk_pkg::*;
#(
  parameter  int DATA_W    = CHK_DATA_W,
  parameter  int REG_W     = CHK_REG_W,
  parameter  int DEPTH     = 8,
  parameter  int END_COUNT = 50,
  parameter  int CNT_W     = 16,
  localparam int LVL_W     = $clog2(DEPTH) + 1
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              exp_valid_i,
  output logic              exp_ready_o,
  input  logic [DATA_W-1:0] exp_pc_i,
  input  logic              exp_we_i,
  input  logic [REG_W-1:0]  exp_rd_i,
  input  logic [DATA_W-1:0] exp_wdata_i,
`ifdef CHK_MEM_EN
  input  logic              exp_mwe_i,
  input  logic [DATA_W-1:0] exp_maddr_i,
  input  logic [DATA_W-1:0] exp_mdata_i,
  input  logic              cmt_mwe_i,
  input  logic [DATA_W-1:0] cmt_maddr_i,
  input  logic [DATA_W-1:0] cmt_mdata_i,
`endif
  input  logic              cmt_valid_i,
  input  logic [DATA_W-1:0] cmt_pc_i,
  input  logic              cmt_we_i,
  input  logic [REG_W-1:0]  cmt_rd_i,
  input  logic [DATA_W-1:0] cmt_wdata_i,
  input  logic              cmt_halt_i,
  output logic              done_o,
  output logic              pass_o,
  output logic              fail_o,
  output logic [3:0]        err_code_o,
  output logic [CNT_W-1:0]  err_index_o,
  output logic [CNT_W-1:0]  commit_cnt_o,
  output logic [LVL_W-1:0]  level_o
);

  if ((longint'(END_COUNT) > ((longint'(1) << CNT_W) - longint'(1))) || (DATA_W != CHK_DATA_W) ||
      (REG_W != CHK_REG_W) || (DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_param_err
    $error("commit_stream_checker: illegal parameter set");
  end

  chk_state_e       state_r, state_nxt_s;
  exp_entry_t       push_ent_s, head_s;
  logic [ENTRY_W-1:0] fifo_dout_s;
  logic             fifo_full_s, fifo_empty_s;
  logic             push_s, pop_s, chk_s, exp_wr_s, cmt_wr_s;
  logic [3:0]       err_s, err_code_r;
  logic [CNT_W-1:0] commit_cnt_r, err_index_r, cnt_inc_s;
  logic             done_r, pass_r, fail_r;

  assign exp_ready_o = !fifo_full_s && !done_r;
  assign push_s      = exp_valid_i && exp_ready_o;
  assign chk_s       = (state_r == RUN) && cmt_valid_i;
  assign pop_s       = chk_s && !fifo_empty_s;
  assign head_s      = fifo_dout_s;
  assign cnt_inc_s   = (commit_cnt_r == {CNT_W{1'b1}}) ? commit_cnt_r : commit_cnt_r + CNT_W'(1);

  // pack the incoming expected entry
  always_comb begin
    push_ent_s       = '0;
    push_ent_s.pc    = exp_pc_i;
    push_ent_s.we    = exp_we_i;
    push_ent_s.rd    = exp_rd_i;
    push_ent_s.wdata = exp_wdata_i;
`ifdef CHK_MEM_EN
    push_ent_s.mwe   = exp_mwe_i;
    push_ent_s.maddr = exp_maddr_i;
    push_ent_s.mdata = exp_mdata_i;
`endif
  end

  commit_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_fifo (
    .clk_i   (clk_i),
    .rst_n   (rst_n),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .din_i   (push_ent_s),
    .dout_o  (fifo_dout_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .level_o (level_o)
  );

  // compare the retiring instruction against the FIFO head
  always_comb begin
    err_s    = 4'b0000;
    exp_wr_s = reg_wr_eff(head_s.we, head_s.rd);
    cmt_wr_s = reg_wr_eff(cmt_we_i, cmt_rd_i);
    if (chk_s) begin
      if (fifo_empty_s) begin
        err_s[ERR_UNDF] = 1'b1;
      end else begin
        err_s[ERR_PC]  = (cmt_pc_i != head_s.pc);
        err_s[ERR_REG] = (exp_wr_s != cmt_wr_s) ||
                         (exp_wr_s && cmt_wr_s &&
                          ((cmt_rd_i != head_s.rd) || (cmt_wdata_i != head_s.wdata)));
`ifdef CHK_MEM_EN
        err_s[ERR_MEM] = (cmt_mwe_i != head_s.mwe) ||
                         (cmt_mwe_i && head_s.mwe &&
                          ((cmt_maddr_i != head_s.maddr) || (cmt_mdata_i != head_s.mdata)));
`endif
      end
    end else begin
      err_s = 4'b0000;
    end
  end

  // verdict FSM next state; a halt only passes when the halting commit itself matched
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_i) state_nxt_s = RUN;
        else         state_nxt_s = IDLE;
      end
      RUN: begin
        if (err_s != 4'b0000) state_nxt_s = FAIL;
        else if (chk_s && ((cnt_inc_s >= CNT_W'(END_COUNT)) || cmt_halt_i)) state_nxt_s = PASS;
        else state_nxt_s = RUN;
      end
      PASS:    state_nxt_s = PASS;
      FAIL:    state_nxt_s = FAIL;
      default: state_nxt_s = IDLE;
    endcase
  end

  // state, counters and latched verdict
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      commit_cnt_r <= {CNT_W{1'b0}};
      err_index_r  <= {CNT_W{1'b0}};
      err_code_r   <= 4'b0000;
      done_r       <= 1'b0;
      pass_r       <= 1'b0;
      fail_r       <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (chk_s) commit_cnt_r <= cnt_inc_s;
      if (err_s != 4'b0000) begin
        err_code_r  <= err_s;
        err_index_r <= commit_cnt_r;
      end
      done_r <= (state_nxt_s == PASS) || (state_nxt_s == FAIL);
      pass_r <= (state_nxt_s == PASS);
      fail_r <= (state_nxt_s == FAIL);
    end
  end

  assign done_o       = done_r;
  assign pass_o       = pass_r;
  assign fail_o       = fail_r;
  assign err_code_o   = err_code_r;
  assign err_index_o  = err_index_r;
  assign commit_cnt_o = commit_cnt_r;

endmodule

// File: tb/tb_commit_stream_checker.sv
// Directed plus randomized bench for commit_stream_checker against a queue-based reference model.
// Memory-compare checks are compiled in when CHK_MEM_EN is defined.
module tb_commit_stream_checker;

  localparam int DEPTH     = 8;
  localparam int END_COUNT = 50;

  logic        clk_i = 1'b0;
  logic        rst_n = 1'b1;
  logic        start_i, exp_valid_i, exp_we_i, cmt_valid_i, cmt_we_i, cmt_halt_i;
  logic [31:0] exp_pc_i, exp_wdata_i, cmt_pc_i, cmt_wdata_i;
  logic [4:0]  exp_rd_i, cmt_rd_i;
  logic        exp_mwe_i, cmt_mwe_i;
  logic [31:0] exp_maddr_i, exp_mdata_i, cmt_maddr_i, cmt_mdata_i;

  logic        exp_ready_o, done_o, pass_o, fail_o;
  logic [3:0]  err_code_o;
  logic [15:0] err_index_o, commit_cnt_o;
  logic [3:0]  level_o;
  logic        e4_ready, e4_done, e4_pass, e4_fail;
  logic [3:0]  e4_err;
  logic [15:0] e4_idx, e4_cnt;
  logic [3:0]  e4_level;

  always #5 clk_i = ~clk_i;

  commit_stream_checker #(.DEPTH(DEPTH), .END_COUNT(END_COUNT)) dut (
    .clk_i(clk_i), .rst_n(rst_n), .start_i(start_i),
    .exp_valid_i(exp_valid_i), .exp_ready_o(exp_ready_o), .exp_pc_i(exp_pc_i),
    .exp_we_i(exp_we_i), .exp_rd_i(exp_rd_i), .exp_wdata_i(exp_wdata_i),
`ifdef CHK_MEM_EN
    .exp_mwe_i(exp_mwe_i), .exp_maddr_i(exp_maddr_i), .exp_mdata_i(exp_mdata_i),
    .cmt_mwe_i(cmt_mwe_i), .cmt_maddr_i(cmt_maddr_i), .cmt_mdata_i(cmt_mdata_i),
`endif
    .cmt_valid_i(cmt_valid_i), .cmt_pc_i(cmt_pc_i), .cmt_we_i(cmt_we_i), .cmt_rd_i(cmt_rd_i),
    .cmt_wdata_i(cmt_wdata_i), .cmt_halt_i(cmt_halt_i),
    .done_o(done_o), .pass_o(pass_o), .fail_o(fail_o), .err_code_o(err_code_o),
    .err_index_o(err_index_o), .commit_cnt_o(commit_cnt_o), .level_o(level_o)
  );

  commit_stream_checker #(.DEPTH(DEPTH), .END_COUNT(4)) u_dut_e4 (
    .clk_i(clk_i), .rst_n(rst_n), .start_i(start_i),
    .exp_valid_i(exp_valid_i), .exp_ready_o(e4_ready), .exp_pc_i(exp_pc_i),
    .exp_we_i(exp_we_i), .exp_rd_i(exp_rd_i), .exp_wdata_i(exp_wdata_i),
`ifdef CHK_MEM_EN
    .exp_mwe_i(exp_mwe_i), .exp_maddr_i(exp_maddr_i), .exp_mdata_i(exp_mdata_i),
    .cmt_mwe_i(cmt_mwe_i), .cmt_maddr_i(cmt_maddr_i), .cmt_mdata_i(cmt_mdata_i),
`endif
    .cmt_valid_i(cmt_valid_i), .cmt_pc_i(cmt_pc_i), .cmt_we_i(cmt_we_i), .cmt_rd_i(cmt_rd_i),
    .cmt_wdata_i(cmt_wdata_i), .cmt_halt_i(cmt_halt_i),
    .done_o(e4_done), .pass_o(e4_pass), .fail_o(e4_fail), .err_code_o(e4_err),
    .err_index_o(e4_idx), .commit_cnt_o(e4_cnt), .level_o(e4_level)
  );

  typedef struct {
    logic [31:0] pc;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] wdata;
    logic        mwe;
    logic [31:0] maddr;
    logic [31:0] mdata;
  } ent_t;

  int   total = 0;
  int   bad   = 0;
  ent_t m_q[$];
  int   m_phase;   // 0 idle, 1 run, 2 pass, 3 fail
  int   m_cnt, m_idx;
  logic [3:0] m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ":done"},  {31'd0, done_o}, (m_phase >= 2) ? 32'd1 : 32'd0);
    chk({tag, ":pass"},  {31'd0, pass_o}, (m_phase == 2) ? 32'd1 : 32'd0);
    chk({tag, ":fail"},  {31'd0, fail_o}, (m_phase == 3) ? 32'd1 : 32'd0);
    chk({tag, ":err"},   {28'd0, err_code_o}, {28'd0, m_err});
    chk({tag, ":idx"},   {16'd0, err_index_o}, m_idx);
    chk({tag, ":cnt"},   {16'd0, commit_cnt_o}, m_cnt);
    chk({tag, ":level"}, {28'd0, level_o}, m_q.size());
    chk({tag, ":ready"}, {31'd0, exp_ready_o},
        ((m_q.size() < DEPTH) && (m_phase < 2)) ? 32'd1 : 32'd0);
  endtask

  function automatic ent_t mk(input logic [31:0] pc, input logic we, input logic [4:0] rd,
                              input logic [31:0] wd);
    ent_t e;
    e.pc = pc; e.we = we; e.rd = rd; e.wdata = wd;
    e.mwe = 1'($urandom_range(0, 1)); e.maddr = $urandom; e.mdata = $urandom;
    return e;
  endfunction

  // Core-side view of a matching commit: fields with no architectural effect are scrambled.
  function automatic ent_t as_core(input ent_t e);
    ent_t c;
    c = e;
    if (!(e.we && e.rd != 5'd0)) begin
      c.we = 1'($urandom_range(0, 1));
      c.rd = c.we ? 5'd0 : 5'($urandom);
      c.wdata = $urandom;
    end
    if (!e.mwe) begin
      c.maddr = $urandom; c.mdata = $urandom;
    end
    return c;
  endfunction

  task automatic set_exp(input ent_t e, input logic v);
    exp_valid_i = v; exp_pc_i = e.pc; exp_we_i = e.we; exp_rd_i = e.rd; exp_wdata_i = e.wdata;
    exp_mwe_i = e.mwe; exp_maddr_i = e.maddr; exp_mdata_i = e.mdata;
  endtask

  task automatic set_cmt(input ent_t e, input logic v, input logic halt);
    cmt_valid_i = v; cmt_pc_i = e.pc; cmt_we_i = e.we; cmt_rd_i = e.rd; cmt_wdata_i = e.wdata;
    cmt_mwe_i = e.mwe; cmt_maddr_i = e.maddr; cmt_mdata_i = e.mdata; cmt_halt_i = halt;
  endtask

  task automatic idle_inputs();
    ent_t z;
    z = mk(32'd0, 1'b0, 5'd0, 32'd0);
    z.mwe = 1'b0;
    start_i = 1'b0;
    set_exp(z, 1'b0);
    set_cmt(z, 1'b0, 1'b0);
  endtask

  // One clock edge with the currently driven inputs; the model applies the commit rules.
  task automatic step(input string tag);
    bit         acc, ew, cw;
    ent_t       h;
    logic [3:0] e;
    acc = exp_valid_i && (m_q.size() < DEPTH) && (m_phase < 2);
    @(posedge clk_i);
    if (m_phase == 1 && cmt_valid_i) begin
      e = 4'b0000;
      if (m_q.size() == 0) begin
        e[2] = 1'b1;
      end else begin
        h = m_q.pop_front();
        if (h.pc != cmt_pc_i) e[0] = 1'b1;
        ew = h.we && (h.rd != 5'd0);
        cw = cmt_we_i && (cmt_rd_i != 5'd0);
        if (ew != cw || (ew && (h.rd != cmt_rd_i || h.wdata != cmt_wdata_i))) e[1] = 1'b1;
`ifdef CHK_MEM_EN
        if (h.mwe != cmt_mwe_i || (h.mwe && (h.maddr != cmt_maddr_i || h.mdata != cmt_mdata_i)))
          e[3] = 1'b1;
`endif
      end
      if (e != 4'b0000) begin
        m_phase = 3; m_err = e; m_idx = m_cnt;
      end
      if (m_cnt < 65535) m_cnt++;
      if (e == 4'b0000 && (m_cnt >= END_COUNT || cmt_halt_i)) m_phase = 2;
    end else if (m_phase == 0 && start_i) begin
      m_phase = 1;
    end
    if (acc) begin
      h.pc = exp_pc_i; h.we = exp_we_i; h.rd = exp_rd_i; h.wdata = exp_wdata_i;
      h.mwe = exp_mwe_i; h.maddr = exp_maddr_i; h.mdata = exp_mdata_i;
      m_q.push_back(h);
    end
    #1;
    check_outputs(tag);
  endtask

  task automatic hard_reset(input string tag);
    rst_n = 1'b0;
    idle_inputs();
    m_q.delete(); m_phase = 0; m_cnt = 0; m_idx = 0; m_err = 4'b0000;
    #1;
    check_outputs(tag);
    @(posedge clk_i);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic push(input ent_t e, input string tag);
    set_exp(e, 1'b1);
    step(tag);
    exp_valid_i = 1'b0;
  endtask

  task automatic start_run();
    start_i = 1'b1;
    step("start");
    start_i = 1'b0;
  endtask

  task automatic commit(input ent_t c, input logic halt, input string tag);
    set_cmt(c, 1'b1, halt);
    step(tag);
    cmt_valid_i = 1'b0;
    cmt_halt_i = 1'b0;
  endtask

  ent_t a[4];
  ent_t c;

  initial begin
    idle_inputs();
    #1;
    hard_reset("reset");

    // matching stream ending in a halt
    a[0] = mk(32'd0, 1'b1, 5'd1, 32'd5);
    a[1] = mk(32'd4, 1'b1, 5'd2, 32'd7);
    a[2] = mk(32'd8, 1'b0, 5'($urandom), $urandom);
    a[3] = mk(32'd12, 1'b0, 5'($urandom), $urandom);
    for (int i = 0; i < 4; i++) push(a[i], "a_push");
    start_run();
    for (int i = 0; i < 3; i++) commit(as_core(a[i]), 1'b0, "a_cmt");
    chk("a_cnt3", {16'd0, commit_cnt_o}, 32'd3);
    commit(as_core(a[3]), 1'b1, "a_halt");
    chk("a_pass", {31'd0, pass_o}, 32'd1);
    chk("a_done", {31'd0, done_o}, 32'd1);

    // register data mismatch on the second commit, verdict then sticky
    hard_reset("b_rst");
    for (int i = 0; i < 3; i++) push(a[i], "b_push");
    start_run();
    commit(as_core(a[0]), 1'b0, "b_cmt0");
    c = a[1]; c.wdata = 32'd6;
    commit(c, 1'b0, "b_bad");
    chk("b_err", {28'd0, err_code_o}, 32'h2);
    chk("b_idx", {16'd0, err_index_o}, 32'd1);
    commit(as_core(a[2]), 1'b0, "b_after");
    chk("b_sticky", {31'd0, fail_o}, 32'd1);

    // underflow
    hard_reset("c_rst");
    start_run();
    commit(mk($urandom, 1'b1, 5'd3, $urandom), 1'b0, "c_undf");
    chk("c_err", {28'd0, err_code_o}, 32'h4);

    // fill to full, commit+push at full, then wrap
    hard_reset("d_rst");
    for (int i = 0; i < 8; i++) push(mk(32'(i * 4), 1'b1, 5'($urandom), $urandom), "d_push");
    chk("d_level8", {28'd0, level_o}, 32'd8);
    chk("d_notready", {31'd0, exp_ready_o}, 32'd0);
    start_run();
    set_exp(mk(32'd32, 1'b1, 5'd9, $urandom), 1'b1);
    commit(as_core(m_q[0]), 1'b0, "d_cmt_full");
    step("d_push_held");
    exp_valid_i = 1'b0;
    chk("d_level_back8", {28'd0, level_o}, 32'd8);
    for (int i = 0; i < 8; i++) commit(as_core(m_q[0]), 1'b0, "d_drain");
    chk("d_cnt9", {16'd0, commit_cnt_o}, 32'd9);
    chk("d_nofail", {31'd0, fail_o}, 32'd0);

    // r0 write normalisation and END_COUNT=4 pass without halt
    hard_reset("e_rst");
    a[0] = mk(32'd0, 1'b1, 5'd0, 32'd9);
    push(a[0], "e_push");
    for (int i = 1; i < 4; i++) push(mk(32'(i * 4), 1'b1, 5'($urandom), $urandom), "e_push");
    start_run();
    c = a[0]; c.we = 1'b0;
    commit(c, 1'b0, "e_r0");
    chk("e_r0_ok", {28'd0, err_code_o}, 32'h0);
    for (int i = 1; i < 3; i++) commit(as_core(m_q[0]), 1'b0, "e_cmt");
    chk("e4_not_yet", {31'd0, e4_pass}, 32'd0);
    commit(as_core(m_q[0]), 1'b0, "e_cmt4");
    chk("e4_pass", {31'd0, e4_pass}, 32'd1);
    chk("e4_done", {31'd0, e4_done}, 32'd1);
    chk("e4_cnt", {16'd0, e4_cnt}, 32'd4);

    // asynchronous reset mid-run
    hard_reset("f_rst");
    for (int i = 0; i < 5; i++) push(mk(32'(i * 4), 1'b1, 5'($urandom), $urandom), "f_push");
    start_run();
    chk("f_level5", {28'd0, level_o}, 32'd5);
    hard_reset("f_async");

`ifdef CHK_MEM_EN
    // store address mismatch
    a[0] = mk(32'd0, 1'b0, 5'd0, 32'd0);
    a[0].mwe = 1'b1; a[0].maddr = 32'h10; a[0].mdata = 32'h5;
    push(a[0], "g_push");
    start_run();
    c = as_core(a[0]); c.maddr = 32'h14;
    commit(c, 1'b0, "g_mem");
    chk("g_err", {28'd0, err_code_o}, 32'h8);
    hard_reset("g_rst");
`endif

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      if (m_phase >= 2 && $urandom_range(0, 3) == 0) hard_reset("r_rst");
      idle_inputs();
      if ($urandom_range(0, 1) == 1)
        set_exp(mk(32'($urandom) & 32'hFFFC, 1'($urandom), 5'($urandom), $urandom), 1'b1);
      start_i = ($urandom_range(0, 7) == 0);
      if (m_q.size() > 0 && $urandom_range(0, 1) == 1) begin
        c = as_core(m_q[0]);
        case ($urandom_range(0, 15))
          0:       c.pc = c.pc ^ 32'h4;
          1:       c.wdata = c.wdata ^ 32'h1;
          2:       c.rd = c.rd ^ 5'h1;
          default: c.pc = c.pc;
        endcase
        set_cmt(c, 1'b1, ($urandom_range(0, 31) == 0));
      end else if ($urandom_range(0, 31) == 0) begin
        set_cmt(mk($urandom, 1'b0, 5'd0, 32'd0), 1'b1, 1'b0);
      end
      step("rand");
    end
    idle_inputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
